// File: rtl/fitbit_pkg.sv
// Shared constants and types for the Fitbit replica datapath.
// Threshold defaults, datapath widths and the monitor FSM encoding.
package fitbit_pkg;

    localparam int DEF_RATE_THRESH  = 32;
    localparam int DEF_EARLY_WINDOW = 9;
    localparam int DEF_HIGH_THRESH  = 64;
    localparam int DEF_HIGH_MIN_RUN = 60;

    localparam int SEC_W  = 8;
    localparam int STEP_W = 8;
    localparam int HACT_W = 16;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_e;

endpackage

// File: rtl/high_activity_tracker.sv
// Tracks consecutive high-rate seconds and credits high-activity time
// once a qualifying run reaches the minimum length.
module high_activity_tracker
    import fitbit_pkg::*;
#(
    parameter int HIGH_THRESH  = DEF_HIGH_THRESH,
    parameter int HIGH_MIN_RUN = DEF_HIGH_MIN_RUN
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              bnd,
    input  logic [STEP_W-1:0] steps,
    output logic [HACT_W-1:0] hact
);

    logic [STEP_W-1:0] run_q, run_d;
    logic [HACT_W-1:0] hact_q, hact_d;
    logic [HACT_W-1:0] inc;
    logic [HACT_W:0]   sum;

    always_comb begin
        run_d = run_q;
        inc   = '0;
        if (bnd) begin
            if (steps > STEP_W'(HIGH_THRESH)) begin
                if (run_q == STEP_W'(HIGH_MIN_RUN)) begin
                    inc = HACT_W'(1);
                end else begin
                    run_d = run_q + 1'b1;
                    // The whole qualifying run is credited at once
                    if (run_d == STEP_W'(HIGH_MIN_RUN))
                        inc = HACT_W'(HIGH_MIN_RUN);
                end
            end else begin
                run_d = '0;
            end
        end
        sum    = {1'b0, hact_q} + {1'b0, inc};
        hact_d = sum[HACT_W] ? '1 : sum[HACT_W-1:0];
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            run_q  <= '0;
            hact_q <= '0;
        end else begin
            run_q  <= run_d;
            hact_q <= hact_d;
        end
    end

    assign hact = hact_q;

endmodule

// File: rtl/step_rate_monitor.sv
// Per-second step-rate analyser: accumulates steps between second
// boundaries and publishes rate, early over-rate count and active time.
module step_rate_monitor
    import fitbit_pkg::*;
#(
    parameter int RATE_THRESH  = DEF_RATE_THRESH,
    parameter int EARLY_WINDOW = DEF_EARLY_WINDOW,
    parameter int HIGH_THRESH  = DEF_HIGH_THRESH,
    parameter int HIGH_MIN_RUN = DEF_HIGH_MIN_RUN
) (
    input  logic              CLK,
    input  logic              RESET,
    input  logic              STEP,
    input  logic [SEC_W-1:0]  NUM_OF_SEC,
    output logic              START_COUNTING,
    output logic [STEP_W-1:0] STEPS_LAST_SEC,
    output logic              SEC_VALID,
    output logic [3:0]        EARLY_OVER_CNT,
    output logic [HACT_W-1:0] HIGH_ACT_SEC
);

    state_e            state_q, state_d;
    logic [SEC_W-1:0]  sec_prev_q, sec_prev_d;
    logic [STEP_W-1:0] acc_q, acc_d;
    logic [STEP_W-1:0] steps_last_q, steps_last_d;
    logic              sec_valid_q, sec_valid_d;
    logic [15:0]       sec_idx_q, sec_idx_d;
    logic [3:0]        early_q, early_d;
    logic              boundary;

    // Any change of the seconds value is a boundary, including 255->0
    assign boundary = (state_q == RUN) && (NUM_OF_SEC != sec_prev_q);

    always_comb begin
        state_d      = state_q;
        sec_prev_d   = NUM_OF_SEC;
        acc_d        = acc_q;
        steps_last_d = steps_last_q;
        sec_valid_d  = 1'b0;
        sec_idx_d    = sec_idx_q;
        early_d      = early_q;
        unique case (state_q)
            IDLE: begin
                if (STEP) begin
                    state_d = RUN;
                    acc_d   = STEP_W'(1);
                end
            end
            RUN: begin
                if (boundary) begin
                    steps_last_d = acc_q;
                    acc_d        = {{(STEP_W-1){1'b0}}, STEP};
                    sec_valid_d  = 1'b1;
                    if (sec_idx_q != '1)
                        sec_idx_d = sec_idx_q + 1'b1;
                    if (sec_idx_d <= 16'(EARLY_WINDOW) &&
                        acc_q > STEP_W'(RATE_THRESH) &&
                        early_q < 4'(EARLY_WINDOW))
                        early_d = early_q + 1'b1;
                end else if (STEP && acc_q != '1) begin
                    acc_d = acc_q + 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            state_q      <= IDLE;
            sec_prev_q   <= '0;
            acc_q        <= '0;
            steps_last_q <= '0;
            sec_valid_q  <= 1'b0;
            sec_idx_q    <= '0;
            early_q      <= '0;
        end else begin
            state_q      <= state_d;
            sec_prev_q   <= sec_prev_d;
            acc_q        <= acc_d;
            steps_last_q <= steps_last_d;
            sec_valid_q  <= sec_valid_d;
            sec_idx_q    <= sec_idx_d;
            early_q      <= early_d;
        end
    end

    high_activity_tracker #(
        .HIGH_THRESH  (HIGH_THRESH),
        .HIGH_MIN_RUN (HIGH_MIN_RUN)
    ) u_hact (
        .clk   (CLK),
        .rst   (RESET),
        .bnd   (boundary),
        .steps (acc_q),
        .hact  (HIGH_ACT_SEC)
    );

    assign START_COUNTING = (state_q == RUN);
    assign STEPS_LAST_SEC = steps_last_q;
    assign SEC_VALID      = sec_valid_q;
    assign EARLY_OVER_CNT = early_q;

endmodule

// File: tb/tb_step_rate_monitor.sv
// Directed self-checking bench for step_rate_monitor.
module tb_step_rate_monitor;

    logic        CLK = 1'b0;
    logic        RESET;
    logic        STEP;
    logic [7:0]  NUM_OF_SEC;
    logic        START_COUNTING;
    logic [7:0]  STEPS_LAST_SEC;
    logic        SEC_VALID;
    logic [3:0]  EARLY_OVER_CNT;
    logic [15:0] HIGH_ACT_SEC;

    int pass_cnt = 0;
    int total_cnt = 0;

    step_rate_monitor dut (
        .CLK            (CLK),
        .RESET          (RESET),
        .STEP           (STEP),
        .NUM_OF_SEC     (NUM_OF_SEC),
        .START_COUNTING (START_COUNTING),
        .STEPS_LAST_SEC (STEPS_LAST_SEC),
        .SEC_VALID      (SEC_VALID),
        .EARLY_OVER_CNT (EARLY_OVER_CNT),
        .HIGH_ACT_SEC   (HIGH_ACT_SEC)
    );

    always #5 CLK = ~CLK;

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    // n step cycles, then the seconds value moves to nxt on the next edge
    task automatic second(input int n, input bit step_at_bnd,
                          input logic [7:0] nxt);
        for (int i = 0; i < n; i++) begin
            STEP = 1'b1;
            tick();
        end
        STEP = step_at_bnd;
        NUM_OF_SEC = nxt;
        tick();
        STEP = 1'b0;
    endtask

    task automatic test_reset();
        int vhigh = 0;
        RESET = 1'b1; STEP = 1'b0; NUM_OF_SEC = 8'd0;
        tick(); tick();
        total_cnt++;
        if ({START_COUNTING, STEPS_LAST_SEC, SEC_VALID, EARLY_OVER_CNT,
             HIGH_ACT_SEC} !== 30'd0)
            $display("FAIL reset_outputs got nonzero start=%0b steps=%0d",
                     START_COUNTING, STEPS_LAST_SEC);
        else pass_cnt++;
        RESET = 1'b0;
        for (int i = 0; i < 1000; i++) begin
            if (i % 97 == 5) NUM_OF_SEC = NUM_OF_SEC + 8'd1;
            tick();
            if (SEC_VALID) vhigh++;
        end
        NUM_OF_SEC = 8'd0;
        tick(); tick();
        total_cnt++;
        if (vhigh !== 0)
            $display("FAIL idle_sec_valid got %0d pulses expected 0", vhigh);
        else pass_cnt++;
        total_cnt++;
        if (START_COUNTING !== 1'b0 || STEPS_LAST_SEC !== 8'd0 ||
            HIGH_ACT_SEC !== 16'd0 || EARLY_OVER_CNT !== 4'd0)
            $display("FAIL idle_outputs start=%0b steps=%0d early=%0d hact=%0d",
                     START_COUNTING, STEPS_LAST_SEC, EARLY_OVER_CNT,
                     HIGH_ACT_SEC);
        else pass_cnt++;
    endtask

    task automatic test_first_second();
        STEP = 1'b1;
        tick();
        total_cnt++;
        if (START_COUNTING !== 1'b1)
            $display("FAIL start_rise got %0b expected 1", START_COUNTING);
        else pass_cnt++;
        for (int i = 0; i < 39; i++) tick();
        STEP = 1'b0;
        NUM_OF_SEC = 8'd1;
        total_cnt++;
        if (SEC_VALID !== 1'b0)
            $display("FAIL valid_early got %0b expected 0", SEC_VALID);
        else pass_cnt++;
        tick();
        total_cnt++;
        if (STEPS_LAST_SEC !== 8'd40 || SEC_VALID !== 1'b1 ||
            EARLY_OVER_CNT !== 4'd1)
            $display("FAIL first_sec got steps=%0d valid=%0b early=%0d expected 40 1 1",
                     STEPS_LAST_SEC, SEC_VALID, EARLY_OVER_CNT);
        else pass_cnt++;
        tick();
        total_cnt++;
        if (SEC_VALID !== 1'b0)
            $display("FAIL valid_one_cycle got %0b expected 0", SEC_VALID);
        else pass_cnt++;
    endtask

    task automatic test_early_window();
        for (int s = 0; s < 12; s++) begin
            second(50, 1'b0, NUM_OF_SEC + 8'd1);
            if (s == 7) begin
                total_cnt++;
                if (EARLY_OVER_CNT !== 4'd9)
                    $display("FAIL early_at_9 got %0d expected 9", EARLY_OVER_CNT);
                else pass_cnt++;
            end
        end
        total_cnt++;
        if (EARLY_OVER_CNT !== 4'd9 || STEPS_LAST_SEC !== 8'd50)
            $display("FAIL early_cap got early=%0d steps=%0d expected 9 50",
                     EARLY_OVER_CNT, STEPS_LAST_SEC);
        else pass_cnt++;
        second(50, 1'b1, NUM_OF_SEC + 8'd1);
        total_cnt++;
        if (STEPS_LAST_SEC !== 8'd50)
            $display("FAIL coincident_cur got %0d expected 50", STEPS_LAST_SEC);
        else pass_cnt++;
        second(10, 1'b0, NUM_OF_SEC + 8'd1);
        total_cnt++;
        if (STEPS_LAST_SEC !== 8'd11)
            $display("FAIL coincident_next got %0d expected 11", STEPS_LAST_SEC);
        else pass_cnt++;
    endtask

    task automatic test_high_activity();
        for (int s = 0; s < 59; s++) second(70, 1'b0, NUM_OF_SEC + 8'd1);
        total_cnt++;
        if (HIGH_ACT_SEC !== 16'd0)
            $display("FAIL hact_59 got %0d expected 0", HIGH_ACT_SEC);
        else pass_cnt++;
        second(70, 1'b0, NUM_OF_SEC + 8'd1);
        total_cnt++;
        if (HIGH_ACT_SEC !== 16'd60)
            $display("FAIL hact_60 got %0d expected 60", HIGH_ACT_SEC);
        else pass_cnt++;
        second(70, 1'b0, NUM_OF_SEC + 8'd1);
        total_cnt++;
        if (HIGH_ACT_SEC !== 16'd61)
            $display("FAIL hact_61 got %0d expected 61", HIGH_ACT_SEC);
        else pass_cnt++;
        second(64, 1'b0, NUM_OF_SEC + 8'd1);
        total_cnt++;
        if (HIGH_ACT_SEC !== 16'd61 || STEPS_LAST_SEC !== 8'd64)
            $display("FAIL hact_thresh got hact=%0d steps=%0d expected 61 64",
                     HIGH_ACT_SEC, STEPS_LAST_SEC);
        else pass_cnt++;
        second(70, 1'b0, NUM_OF_SEC + 8'd1);
        total_cnt++;
        if (HIGH_ACT_SEC !== 16'd61)
            $display("FAIL hact_run_cleared got %0d expected 61", HIGH_ACT_SEC);
        else pass_cnt++;
    endtask

    task automatic test_sat_wrap();
        second(5, 1'b0, 8'd255);
        total_cnt++;
        if (STEPS_LAST_SEC !== 8'd5 || SEC_VALID !== 1'b1)
            $display("FAIL to_255 got steps=%0d valid=%0b expected 5 1",
                     STEPS_LAST_SEC, SEC_VALID);
        else pass_cnt++;
        tick();
        second(300, 1'b0, 8'd0);
        total_cnt++;
        if (STEPS_LAST_SEC !== 8'd255 || SEC_VALID !== 1'b1)
            $display("FAIL wrap_sat got steps=%0d valid=%0b expected 255 1",
                     STEPS_LAST_SEC, SEC_VALID);
        else pass_cnt++;
        total_cnt++;
        if (EARLY_OVER_CNT !== 4'd9 || HIGH_ACT_SEC !== 16'd61)
            $display("FAIL wrap_hold got early=%0d hact=%0d expected 9 61",
                     EARLY_OVER_CNT, HIGH_ACT_SEC);
        else pass_cnt++;
    endtask

    task automatic test_back_to_back();
        STEP = 1'b1; NUM_OF_SEC = 8'd1;
        tick();
        total_cnt++;
        if (STEPS_LAST_SEC !== 8'd0 || SEC_VALID !== 1'b1)
            $display("FAIL b2b_0 got steps=%0d valid=%0b expected 0 1",
                     STEPS_LAST_SEC, SEC_VALID);
        else pass_cnt++;
        STEP = 1'b1; NUM_OF_SEC = 8'd2;
        tick();
        total_cnt++;
        if (STEPS_LAST_SEC !== 8'd1 || SEC_VALID !== 1'b1)
            $display("FAIL b2b_1 got steps=%0d valid=%0b expected 1 1",
                     STEPS_LAST_SEC, SEC_VALID);
        else pass_cnt++;
        STEP = 1'b0; NUM_OF_SEC = 8'd3;
        tick();
        total_cnt++;
        if (STEPS_LAST_SEC !== 8'd1 || SEC_VALID !== 1'b1)
            $display("FAIL b2b_2 got steps=%0d valid=%0b expected 1 1",
                     STEPS_LAST_SEC, SEC_VALID);
        else pass_cnt++;
        tick();
        total_cnt++;
        if (SEC_VALID !== 1'b0)
            $display("FAIL b2b_end got %0b expected 0", SEC_VALID);
        else pass_cnt++;
    endtask

    task automatic test_reset_mid();
        for (int i = 0; i < 20; i++) begin
            STEP = 1'b1;
            tick();
        end
        STEP = 1'b0;
        #2 RESET = 1'b1;
        #1;
        total_cnt++;
        if ({START_COUNTING, STEPS_LAST_SEC, SEC_VALID, EARLY_OVER_CNT,
             HIGH_ACT_SEC} !== 30'd0)
            $display("FAIL async_reset start=%0b steps=%0d early=%0d hact=%0d",
                     START_COUNTING, STEPS_LAST_SEC, EARLY_OVER_CNT,
                     HIGH_ACT_SEC);
        else pass_cnt++;
        tick();
        RESET = 1'b0;
        for (int i = 0; i < 5; i++) begin
            NUM_OF_SEC = NUM_OF_SEC + 8'd1;
            tick();
        end
        tick();
        total_cnt++;
        if (START_COUNTING !== 1'b0 || SEC_VALID !== 1'b0)
            $display("FAIL post_reset_idle start=%0b valid=%0b expected 0 0",
                     START_COUNTING, SEC_VALID);
        else pass_cnt++;
        second(1, 1'b0, NUM_OF_SEC + 8'd1);
        total_cnt++;
        if (START_COUNTING !== 1'b1 || STEPS_LAST_SEC !== 8'd1 ||
            SEC_VALID !== 1'b1 || EARLY_OVER_CNT !== 4'd0)
            $display("FAIL restart got start=%0b steps=%0d valid=%0b early=%0d",
                     START_COUNTING, STEPS_LAST_SEC, SEC_VALID, EARLY_OVER_CNT);
        else pass_cnt++;
    endtask

    initial begin
        test_reset();
        test_first_second();
        test_early_window();
        test_high_activity();
        test_sat_wrap();
        test_back_to_back();
        test_reset_mid();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
